wb_ram: RTL

Wishbone B4 classic slave memory, downstream of the CPU bus master (`wb_cpu_bus`). It decodes its own address window and performs word, halfword and byte accesses under `SEL_I` byte lanes. Each access completes with a programmable number of wait states and a one-cycle `ACK_O`. It is the CPU's main data/instruction RAM and doubles as a latency-configurable target for bus verification.

---
 rtl/wb_ram.sv | 139 +++++++++++++
 1 files changed

// File: rtl/wb_ram.sv
// Wishbone B4 classic slave RAM with its own address decode, byte-lane writes,
// a programmable number of wait states and a single-cycle ACK.
module wb_ram #(
    parameter int unsigned ADDR_BITS   = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [31:0] ADR_I,
    input  logic [3:0]  SEL_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t                 state_reg;
    logic [3:0]             count_reg;
    logic                   ack_reg;
    logic [31:0]            dat_o_reg;
    logic [ADDR_BITS-1:0]   idx_reg;
    logic                   we_reg;
    logic [3:0]             sel_reg;
    logic [31:0]            wdat_reg;

    logic [31:0]            mem [DEPTH];

    logic                   hit;
    logic                   req_hit;
    logic                   commit;
    logic                   wr_en;
    logic                   rd_en;
    logic [ADDR_BITS-1:0]   acc_idx;
    logic                   acc_we;
    logic [3:0]             acc_sel;
    logic [31:0]            acc_dat;
    logic [1:0]             unused_adr_lsb;

    assign unused_adr_lsb = ADR_I[1:0];

    assign hit     = (ADR_I[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
    assign req_hit = CYC_I & STB_I & hit;

    // With zero wait states the access commits on the sampling edge itself,
    // so the live bus fields feed the memory; otherwise the latched copy does.
    always_comb begin
        acc_idx = idx_reg;
        acc_we  = we_reg;
        acc_sel = sel_reg;
        acc_dat = wdat_reg;
        if (state_reg == S_IDLE) begin
            acc_idx = ADR_I[ADDR_BITS+1:2];
            acc_we  = WE_I;
            acc_sel = SEL_I;
            acc_dat = DAT_I;
        end
    end

    always_comb begin
        commit = 1'b0;
        if (!RST_I && CYC_I) begin
            if (state_reg == S_IDLE)
                commit = req_hit && (WAIT_STATES == 0);
            else if (state_reg == S_WAIT)
                commit = (count_reg == 4'd0);
        end
    end

    assign wr_en = commit &  acc_we;
    assign rd_en = commit & ~acc_we;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_reg <= S_IDLE;
            count_reg <= 4'd0;
            ack_reg   <= 1'b0;
        end else begin
            ack_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (req_hit) begin
                        idx_reg  <= ADR_I[ADDR_BITS+1:2];
                        we_reg   <= WE_I;
                        sel_reg  <= SEL_I;
                        wdat_reg <= DAT_I;
                        if (WAIT_STATES == 0) begin
                            state_reg <= S_ACK;
                            ack_reg   <= 1'b1;
                        end else begin
                            count_reg <= 4'(WAIT_STATES - 1);
                            state_reg <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!CYC_I) begin
                        state_reg <= S_IDLE;
                    end else if (count_reg == 4'd0) begin
                        state_reg <= S_ACK;
                        ack_reg   <= 1'b1;
                    end else begin
                        count_reg <= count_reg - 4'd1;
                    end
                end
                S_ACK:   state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Byte-enabled write port; contents survive reset.
    always_ff @(posedge CLK_I) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_sel[b])
                    mem[acc_idx][8*b +: 8] <= acc_dat[8*b +: 8];
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I)
            dat_o_reg <= 32'h0;
        else if (rd_en)
            dat_o_reg <= mem[acc_idx];
    end

    assign DAT_O = dat_o_reg;
    assign ACK_O = ack_reg;

endmodule
